// File: rtl/regfile_mp_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_mp_if : decode/writeback access bundle for regfile_mp            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic                ready;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic                pset;
  logic [AW-1:0]       psa;
  logic                pclr_on_we;

  modport master (
    input  ready, rd, rbusy,
    output we, wa, wd, ra, pset, psa, pclr_on_we
  );

  modport slave (
    output ready, rd, rbusy,
    input  we, wa, wd, ra, pset, psa, pclr_on_we
  );
endinterface

`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_mp : multi-read-port register file with clear sweep + scoreboard |
// | Optional macro RF_BYPASS_EN enables same-cycle write-to-read bypass.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        reset,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [0:0]    S_CLEAR = 1'b0;
  localparam logic [0:0]    S_READY = 1'b1;
  localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [NREGS-1:0] pend_q, pend_d;
  logic [XLEN-1:0] rf_q [NREGS];

  logic            rf_we;
  logic [AW-1:0]   rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic            is_ready, wr_drop, wr_ok, pclr_ok, pset_ok;

  always_comb begin
    is_ready = (state_q == S_READY);
    wr_drop  = (ZERO_REG != 0) && (bus.wa == '0);
    wr_ok    = is_ready && bus.we && !wr_drop;
    pclr_ok  = is_ready && bus.we && bus.pclr_on_we;
    pset_ok  = is_ready && bus.pset && !((ZERO_REG != 0) && (bus.psa == '0));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    rf_we   = 1'b0;
    rf_wa   = bus.wa;
    rf_wd   = bus.wd;
    if (state_q == S_CLEAR) begin
      rf_we = 1'b1;
      rf_wa = cnt_q;
      rf_wd = '0;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) state_d = S_READY;
    end else begin
      rf_we = wr_ok;
      // Clear first so a simultaneous set to the same register wins.
      if (pclr_ok) pend_d[bus.wa]  = 1'b0;
      if (pset_ok) pend_d[bus.psa] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // The array itself has no reset; it is initialised by the sweep instead.
  always_ff @(posedge clk) begin
    if (!reset && rf_we) rf_q[rf_wa] <= rf_wd;
  end

  assign bus.ready = is_ready;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra_i;
    logic [XLEN-1:0] rd_i;
    logic            busy_i;

    assign ra_i = bus.ra[i*AW +: AW];

    always_comb begin
      rd_i   = rf_q[ra_i];
      busy_i = pend_q[ra_i];
`ifdef RF_BYPASS_EN
      if (wr_ok && (ra_i == bus.wa)) rd_i = bus.wd;
      if (pclr_ok && (ra_i == bus.wa) && !(pset_ok && (bus.psa == bus.wa))) busy_i = 1'b0;
`endif
      if (!is_ready || ((ZERO_REG != 0) && (ra_i == '0))) begin
        rd_i   = '0;
        busy_i = 1'b0;
      end
    end

    assign bus.rd[i*XLEN +: XLEN] = rd_i;
    assign bus.rbusy[i]           = busy_i;
  end
endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_mp : randomized + directed self-checking bench for regfile_mp |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_regfile_mp;
  localparam int NA = 32;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_a ();
  regfile_mp_if #(.XLEN(64), .NREGS(16), .NRD(3)) bus_b ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a));
  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model of instance A: array, pending set, cycles left in sweep.
  logic [31:0] m_mem [NA];
  bit   [NA-1:0] m_pend = '0;
  bit   m_ready = 1'b0;
  int   m_left  = NA;

  always @(posedge clk) begin
    if (rst_a) begin
      m_ready = 1'b0;
      m_left  = NA;
      m_pend  = '0;
    end else if (!m_ready) begin
      m_mem[NA - m_left] = 32'd0;
      m_left = m_left - 1;
      if (m_left == 0) m_ready = 1'b1;
    end else begin
      if (bus_a.we && bus_a.wa != 0) m_mem[bus_a.wa] = bus_a.wd;
      if (bus_a.we && bus_a.pclr_on_we) m_pend[bus_a.wa] = 1'b0;
      if (bus_a.pset && bus_a.psa != 0) m_pend[bus_a.psa] = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("ready", {63'd0, bus_a.ready}, {63'd0, m_ready});
    for (int p = 0; p < 2; p++) begin
      logic [4:0]  a;
      logic [31:0] e_rd;
      logic        e_busy;
      a      = bus_a.ra[p*5 +: 5];
      e_rd   = m_mem[a];
      e_busy = m_pend[a];
`ifdef RF_BYPASS_EN
      if (bus_a.we && bus_a.wa != 0 && a == bus_a.wa) e_rd = bus_a.wd;
      if (bus_a.we && bus_a.pclr_on_we && a == bus_a.wa &&
          !(bus_a.pset && bus_a.psa == bus_a.wa && bus_a.psa != 0)) e_busy = 1'b0;
`endif
      if (!m_ready || a == 0) begin
        e_rd   = 32'd0;
        e_busy = 1'b0;
      end
      chk($sformatf("rd%0d", p), {32'd0, bus_a.rd[p*32 +: 32]}, {32'd0, e_rd});
      chk($sformatf("rbusy%0d", p), {63'd0, bus_a.rbusy[p]}, {63'd0, e_busy});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.we = 1'b0; bus_a.pset = 1'b0; bus_a.pclr_on_we = 1'b0;
  endtask

  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus_a.we = 0; bus_a.wa = 0; bus_a.wd = 0; bus_a.ra = 0;
    bus_a.pset = 0; bus_a.psa = 0; bus_a.pclr_on_we = 0;
    bus_b.we = 0; bus_b.wa = 0; bus_b.wd = 0; bus_b.ra = 0;
    bus_b.pset = 0; bus_b.psa = 0; bus_b.pclr_on_we = 0;

    // Sweep after a 3-cycle reset.
    repeat (3) step();
    chk("reset_ready", {63'd0, bus_a.ready}, 64'd0);
    rst_a = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("sweep_ready", {63'd0, bus_a.ready}, (k == 32) ? 64'd1 : 64'd0);
    end
    for (int r = 0; r < 32; r++) begin
      bus_a.ra = {5'(r), 5'(31 - r)};
      step();
      chk("sweep_zero0", {32'd0, bus_a.rd[31:0]}, 64'd0);
      chk("sweep_zero1", {32'd0, bus_a.rd[63:32]}, 64'd0);
    end

    // Reset mid-sweep, plus a write issued during the sweep.
    rst_a = 1'b1; step(); rst_a = 1'b0;
    repeat (10) step();
    rst_a = 1'b1; step(); rst_a = 1'b0;
    n = 0;
    while (!bus_a.ready && n < 100) begin
      if (n == 5) begin bus_a.we = 1; bus_a.wa = 5'd3; bus_a.wd = 32'hCAFEF00D; end
      step();
      idle_a();
      n++;
    end
    chk("midsweep_latency", 64'(n), 64'd32);
    bus_a.ra = {5'd0, 5'd3};
    #1 chk("sweep_write_ignored", {32'd0, bus_a.rd[31:0]}, 64'd0);

    // Write/read and zero register.
    bus_a.we = 1; bus_a.wa = 5'd5; bus_a.wd = 32'hDEADBEEF;
    step(); idle_a();
    bus_a.ra = {5'd5, 5'd5};
    #1;
    chk("wr_rd_p0", {32'd0, bus_a.rd[31:0]}, 64'hDEADBEEF);
    chk("wr_rd_p1", {32'd0, bus_a.rd[63:32]}, 64'hDEADBEEF);
    bus_a.we = 1; bus_a.wa = 5'd0; bus_a.wd = 32'h1234;
    step(); idle_a();
    bus_a.ra = {5'd5, 5'd0};
    #1 chk("zero_reg", {32'd0, bus_a.rd[31:0]}, 64'd0);

    // Scoreboard set / clear / set-wins.
    bus_a.ra = {5'd0, 5'd7};
    bus_a.pset = 1; bus_a.psa = 5'd7;
    step(); idle_a();
    chk("pend_set", {63'd0, bus_a.rbusy[0]}, 64'd1);
    bus_a.we = 1; bus_a.wa = 5'd7; bus_a.wd = 32'h77; bus_a.pclr_on_we = 1;
    step(); idle_a();
    chk("pend_clr", {63'd0, bus_a.rbusy[0]}, 64'd0);
    bus_a.we = 1; bus_a.wa = 5'd7; bus_a.wd = 32'h78; bus_a.pclr_on_we = 1;
    bus_a.pset = 1; bus_a.psa = 5'd7;
    step(); idle_a();
    chk("pend_set_wins", {63'd0, bus_a.rbusy[0]}, 64'd1);

    // Bypass behaviour.
    bus_a.we = 1; bus_a.wa = 5'd9; bus_a.wd = 32'h11111111;
    step(); idle_a();
    bus_a.ra = {5'd0, 5'd9};
    bus_a.we = 1; bus_a.wa = 5'd9; bus_a.wd = 32'hA5A5A5A5;
    #1;
`ifdef RF_BYPASS_EN
    chk("bypass_same", {32'd0, bus_a.rd[31:0]}, 64'hA5A5A5A5);
`else
    chk("bypass_same", {32'd0, bus_a.rd[31:0]}, 64'h11111111);
`endif
    step(); idle_a();
    chk("bypass_next", {32'd0, bus_a.rd[31:0]}, 64'hA5A5A5A5);

    // Randomized traffic including occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst_a = ($urandom_range(0, 399) == 0);
      bus_a.we = 1'($urandom_range(0, 1));
      bus_a.wa = pick_addr();
      bus_a.wd = $urandom;
      bus_a.ra = {pick_addr(), pick_addr()};
      bus_a.pset = 1'($urandom_range(0, 2) == 0);
      bus_a.psa = pick_addr();
      bus_a.pclr_on_we = 1'($urandom_range(0, 1));
      step();
    end
    rst_a = 1'b0; idle_a();

    // Second configuration: 64-bit, 16 regs, 3 ports, ordinary reg 0.
    rst_b = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("b_sweep_ready", {63'd0, bus_b.ready}, (k == 16) ? 64'd1 : 64'd0);
    end
    bus_b.we = 1; bus_b.wa = 4'd0; bus_b.wd = 64'hFFFF_FFFF_FFFF_FFFF;
    step(); bus_b.we = 0;
    bus_b.ra = 12'h000;
    #1;
    for (int p = 0; p < 3; p++)
      chk($sformatf("b_reg0_p%0d", p), bus_b.rd[p*64 +: 64], 64'hFFFF_FFFF_FFFF_FFFF);
    bus_b.pset = 1; bus_b.psa = 4'd0;
    step(); bus_b.pset = 0;
    chk("b_pend_reg0", {61'd0, bus_b.rbusy}, 64'd7);
    bus_b.we = 1; bus_b.wa = 4'd15; bus_b.wd = 64'h0123_4567_89AB_CDEF;
    step(); bus_b.we = 0;
    bus_b.ra = {4'd15, 4'd0, 4'd3};
    #1;
    chk("b_reg15_p2", bus_b.rd[191:128], 64'h0123_4567_89AB_CDEF);
    chk("b_reg3_p0", bus_b.rd[63:0], 64'd0);

    step();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port integer register file, the next generation of the core's 2R1W register file. Adds a synchronous-reset hardware clear sweep, per-register pending (scoreboard) bits for hazard detection, and a configurable zero register. Sits in the decode/writeback stage of the RISC-V core. Decode reads operands and marks destinations pending; writeback writes results and clears the pending bits.

Parameters:
XLEN, 32, data width in bits.
NREGS, 32, register count; power of two, >=2; AW = $clog2(NREGS) is a derived localparam.
NRD, 2, number of read ports (1..4).
ZERO_REG, 1, 1 = register 0 is hardwired zero; 0 = register 0 is an ordinary register.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
ready  out  1  high once the clear sweep is done; low during reset and the sweep.
we  in  1  write enable.
wa  in  AW  write address.
wd  in  XLEN  write data.
ra  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
rd  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]; combinational.
rbusy  out  NRD  pending bit of each read port's register; combinational.
pset  in  1  mark register psa pending.
psa  in  AW  address to mark pending.
pclr_on_we  in  1  when high, a write also clears the pending bit of wa.

Behaviour:
- State machine has two states: CLEAR and READY.
- Reset:
  - While reset=1: state=CLEAR, sweep counter cnt=0, all pending bits=0, ready=0.
  - Register array contents are not touched while reset=1.
- CLEAR:
  - Each posedge with reset=0 writes 0 to rf[cnt], then cnt++.
  - When cnt==NREGS-1 is written, go to READY. ready=1 exactly NREGS posedges after reset deasserts.
  - we and pset are ignored. rd reads all 0. rbusy reads all 0.
- Reset mid-sweep: cnt returns to 0 and the sweep restarts from the beginning.
- READY, write:
  - On posedge with we=1, rf[wa] <= wd.
  - If ZERO_REG=1 and wa==0, the write is dropped.
- READY, read:
  - rd port i = rf[ra_i].
  - If ZERO_REG=1 and ra_i==0, rd port i = 0 and rbusy[i] = 0.
- Pending bits:
  - pset=1 sets pend[psa] on posedge.
  - we=1 && pclr_on_we=1 clears pend[wa] on posedge.
  - Same address set and cleared in the same cycle: set wins (a new producer has been issued).
  - pset to register 0 with ZERO_REG=1 is ignored.
  - rbusy[i] = pend[ra_i], registered value (no forwarding of pset).
- Multiple read ports may use the same address; each returns an identical value.
- Width: wd is stored verbatim, no extension or truncation.
- No output is X after the sweep, because every register has been written.

Optional Feature:
RF_BYPASS_EN
- Defined:
  - Write-to-read bypass. If we=1, the write is not dropped, and ra_i==wa, then rd port i = wd in the same cycle.
  - Likewise, if the clearing write would clear pend[ra_i], rbusy[i] = 0 in the same cycle.
- Undefined:
  - rd returns the pre-write array value.
  - rbusy reflects the pending bit before the posedge.

Test Plan:
- Sweep: hold reset for 3 cycles, then release with NREGS=32 -> ready=0 for 32 posedges and =1 on the 33rd cycle. Every register then reads 0.
- Reset mid-sweep: assert reset at sweep cycle 10, release after 1 cycle -> ready rises 32 posedges after release. A we=1 issued during the sweep has no effect, and that register reads 0.
- Write/read: write wa=5, wd=0xDEADBEEF. Next cycle read ra port0=5 and port1=5 -> both return 0xDEADBEEF. Write wa=0 with 0x1234 (ZERO_REG=1) -> ra=0 returns 0.
- Scoreboard:
  - pset psa=7 -> next cycle rbusy=1 for ra=7.
  - we wa=7 with pclr_on_we=1 -> rbusy=0 the following cycle.
  - pset psa=7 together with a clearing write to wa=7 -> pending stays 1.
- Bypass: we wa=9, wd=0xA5A5A5A5 while ra=9 in the same cycle.
  - With RF_BYPASS_EN: rd=0xA5A5A5A5 in the same cycle.
  - Without RF_BYPASS_EN: rd=old value, and 0xA5A5A5A5 appears the next cycle.
- Parameter sweep: XLEN=64, NREGS=16, NRD=3, ZERO_REG=0 -> the sweep takes 16 cycles. A write to reg 0 with 0xFFFF_FFFF_FFFF_FFFF reads back intact on all 3 ports.
